// File: rtl/spin_pkg.sv
// Shared definitions for the spinner angle accumulator.
//   - state codes for the two-state arm/run sequencer
//   - saturation limit helper for the signed fractional accumulator
package spin_pkg;

  // Sequencer states: one priming cycle after reset, then free-running.
  localparam logic [0:0] StArm = 1'b0;
  localparam logic [0:0] StRun = 1'b1;

  localparam int unsigned AccWDefault = 12;

  // Largest magnitude the accumulator may hold; symmetric so it never wraps.
  function automatic int unsigned sat_lim(int unsigned acc_w);
    return (32'd1 << (acc_w - 1)) - 32'd1;
  endfunction

  localparam int unsigned AccMaxDefault = sat_lim(AccWDefault);

endpackage

// File: rtl/spin_edge_det.sv
// Registered edge detector for a single-bit level.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   arm      while high, history is primed with the live input so an edge
//            present at reset release is swallowed
//   d        level to watch
//   hit      Rise=1: rising edge, Rise=0: any change; RegOut=1 delays hit by
//            one extra register stage
module spin_edge_det #(
  parameter bit Rise   = 1'b1,
  parameter bit RegOut = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arm,
  input  logic d,
  output logic hit
);

  logic sync_q;
  logic prev_q;
  logic hit_c;
  logic hit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      sync_q <= d;
      prev_q <= arm ? d : sync_q;
      hit_q  <= hit_c;
    end
  end

  always_comb begin
    hit_c = 1'b0;
    if (!arm) begin
      hit_c = Rise ? (sync_q & ~prev_q) : (sync_q ^ prev_q);
    end
  end

  assign hit = RegOut ? hit_q : hit_c;

endmodule

// File: rtl/spin_angle_accum.sv
// Spinner / dial angle accumulator.
// Turns frame-stepped left/right buttons and the HPS spinner delta stream into
// a wrapping OUT_W-bit angle code.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   fast      button step is FAST_MUL instead of 1
//   minus     rotate negative (level)
//   plus      rotate positive (level)
//   strobe    frame tick (vsync); buttons step once per rising edge
//   spin_in   [8] toggles per new sample, [7:0] signed delta
//   spin_out  current angle
//   moved     one-cycle pulse when spin_out changes
//   dir       direction of last change, 1 = positive
module spin_angle_accum
  import spin_pkg::*;
#(
  parameter int unsigned OUT_W    = 4,
  parameter int unsigned DIV      = 8,
  parameter int unsigned FAST_MUL = 2,
  parameter int unsigned ACC_W    = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fast,
  input  logic             minus,
  input  logic             plus,
  input  logic             strobe,
  input  logic [8:0]       spin_in,
  output logic [OUT_W-1:0] spin_out,
  output logic             moved,
  output logic             dir
);

  localparam logic signed [ACC_W:0]   DivS    = (ACC_W + 1)'(DIV);
  localparam logic signed [ACC_W:0]   AccMaxS = (ACC_W + 1)'(sat_lim(ACC_W));
  localparam logic signed [ACC_W-1:0] AccMaxA = ACC_W'(sat_lim(ACC_W));
  localparam logic signed [4:0]       FastS   = 5'(FAST_MUL);

  logic [0:0]              state_q, state_d;
  logic [7:0]              delta_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        spin_out_q, spin_out_d;
  logic                    moved_q, moved_d;
  logic                    dir_q, dir_d;

  logic                    run;
  logic                    tick;
  logic                    new_sample;
  logic signed [ACC_W:0]   acc_x;
  logic signed [ACC_W:0]   delta_x;
  logic signed [ACC_W:0]   sum;
  logic                    step_up, step_dn;
  logic signed [4:0]       step_s, btn_v, stp_v, move;

  assign run = (state_q == StRun);

  // Strobe tick carries an extra register so button and spin paths share the
  // same two-edge latency from input sampling to angle change.
  spin_edge_det #(
    .Rise  (1'b1),
    .RegOut(1'b1)
  ) u_strobe_det (
    .clk    (clk),
    .reset_n(reset_n),
    .arm    (!run),
    .d      (strobe),
    .hit    (tick)
  );

  spin_edge_det #(
    .Rise  (1'b0),
    .RegOut(1'b0)
  ) u_toggle_det (
    .clk    (clk),
    .reset_n(reset_n),
    .arm    (!run),
    .d      (spin_in[8]),
    .hit    (new_sample)
  );

  always_comb begin
    state_d = StRun;
  end

  // Accumulator: at most one DIV-sized step per cycle drains the residual.
  always_comb begin
    acc_x   = {acc_q[ACC_W-1], acc_q};
    delta_x = {{(ACC_W - 7){delta_q[7]}}, delta_q};
    step_up = run && (acc_x >= DivS);
    step_dn = run && (acc_x <= -DivS);
    sum     = acc_x;
    if (run && new_sample) begin
      sum = sum + delta_x;
    end
    if (step_up) begin
      sum = sum - DivS;
    end else if (step_dn) begin
      sum = sum + DivS;
    end
    if (sum > AccMaxS) begin
      acc_d = AccMaxA;
    end else if (sum < -AccMaxS) begin
      acc_d = -AccMaxA;
    end else begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  // Angle: button and spinner contributions add and may cancel.
  always_comb begin
    step_s = fast ? FastS : 5'sd1;
    btn_v  = 5'sd0;
    if (run && tick) begin
      if (plus && !minus) begin
        btn_v = step_s;
      end else if (minus && !plus) begin
        btn_v = -step_s;
      end
    end
    stp_v      = step_up ? 5'sd1 : (step_dn ? -5'sd1 : 5'sd0);
    move       = btn_v + stp_v;
    spin_out_d = spin_out_q + OUT_W'(move);
    moved_d    = (move != 5'sd0);
    dir_d      = moved_d ? !move[4] : dir_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StArm;
      delta_q    <= 8'h00;
      acc_q      <= '0;
      spin_out_q <= '0;
      moved_q    <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      delta_q    <= spin_in[7:0];
      acc_q      <= acc_d;
      spin_out_q <= spin_out_d;
      moved_q    <= moved_d;
      dir_q      <= dir_d;
    end
  end

  assign spin_out = spin_out_q;
  assign moved    = moved_q;
  assign dir      = dir_q;

endmodule

// File: tb/tb_spin_angle_accum.sv
module tb_spin_angle_accum;

  localparam int OUT_W    = 4;
  localparam int DIV      = 8;
  localparam int FAST_MUL = 2;
  localparam int ACC_W    = 12;
  localparam int LIM      = (1 << (ACC_W - 1)) - 1;
  localparam int MASK     = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             fast = 1'b0, minus = 1'b0, plus = 1'b0, strobe = 1'b0;
  logic [8:0]       spin_in = 9'h000;
  logic [OUT_W-1:0] spin_out;
  logic             moved, dir;

  int total = 0;
  int bad = 0;

  spin_angle_accum #(
    .OUT_W   (OUT_W),
    .DIV     (DIV),
    .FAST_MUL(FAST_MUL),
    .ACC_W   (ACC_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fast    (fast),
    .minus   (minus),
    .plus    (plus),
    .strobe  (strobe),
    .spin_in (spin_in),
    .spin_out(spin_out),
    .moved   (moved),
    .dir     (dir)
  );

  always #5 clk = ~clk;

  // Reference model: events scheduled by the time the inputs are sampled.
  // A spinner sample lands in the accumulator one edge later; a strobe rise
  // moves the angle two edges later; a DIV-sized step is taken from the
  // accumulator value that was present before the edge.
  int       acc_m, angle_m, pend_d, stp, btn, mv, s;
  bit       arm_m, pend_v, last_tog, last_strb;
  bit [1:0] tick_pipe;
  logic [OUT_W:0] exp_q[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      acc_m = 0; angle_m = 0; arm_m = 1'b1; pend_v = 1'b0; tick_pipe = 2'b00;
    end else if (arm_m) begin
      arm_m = 1'b0;
      last_tog = spin_in[8];
      last_strb = strobe;
    end else begin
      stp = (acc_m >= DIV) ? 1 : ((acc_m <= -DIV) ? -1 : 0);
      acc_m = acc_m + (pend_v ? pend_d : 0) - stp * DIV;
      if (acc_m > LIM) acc_m = LIM;
      if (acc_m < -LIM) acc_m = -LIM;
      btn = 0;
      if (tick_pipe[1]) begin
        s = fast ? FAST_MUL : 1;
        if (plus && !minus) btn = s;
        else if (minus && !plus) btn = -s;
      end
      mv = btn + stp;
      if (mv != 0) begin
        angle_m = (angle_m + mv) & MASK;
        exp_q.push_back({(mv > 0), OUT_W'(angle_m)});
      end
      tick_pipe = {tick_pipe[0], strobe && !last_strb};
      pend_v = (spin_in[8] != last_tog);
      pend_d = $signed(spin_in[7:0]);
      last_tog = spin_in[8];
      last_strb = strobe;
    end
  end

  // Monitor: every moved pulse must match the next predicted change.
  logic [OUT_W:0] e;
  always @(negedge clk) begin
    if (reset_n && moved) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_move: got spin_out=%0h dir=%0b, required no move",
                 spin_out, dir);
      end else begin
        e = exp_q.pop_front();
        if ({dir, spin_out} !== e) begin
          bad++;
          $display("FAIL move_value: got dir=%0b spin_out=%0h, required dir=%0b spin_out=%0h",
                   dir, spin_out, e[OUT_W], e[OUT_W-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic cyc(input bit strb, input bit tog, input logic [7:0] d);
    strobe = strb;
    if (tog) spin_in = {~spin_in[8], d};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  // Buttons change only together with a strobe rise and hold until the next.
  task automatic pulse(input bit p, input bit m, input bit f);
    plus = p; minus = m; fast = f;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    idle(3);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout, required natural end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] d;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_spin_out", int'(spin_out), 0);
    check("reset_moved", int'(moved), 0);
    check("reset_dir", int'(dir), 0);
    spin_in = 9'h105;
    reset_n = 1'b1;
    idle(6);
    check("arm_absorbs_toggle", int'(spin_out), 0);

    // Buttons: plus x3, fast, minus, both held.
    pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
    pulse(1, 0, 1);
    check("fast_step", int'(spin_out), 5);
    pulse(0, 1, 0);
    pulse(1, 1, 0); pulse(1, 1, 0);
    check("both_held", int'(spin_out), 4);
    plus = 0; minus = 0; fast = 0;

    // Spinner: drain in DIV steps, negative delta, same-cycle cancel.
    cyc(1'b0, 1'b1, 8'd20); idle(5);
    cyc(1'b0, 1'b1, 8'd4);  idle(4);
    cyc(1'b0, 1'b1, 8'hF8); idle(4);
    check("spin_drain", int'(spin_out), (4 + 3 - 1) & MASK);
    plus = 1;
    cyc(1'b1, 1'b1, 8'hF8); cyc(1'b1, 1'b0, 8'h00); idle(4);
    check("tick_cancels_step", int'(spin_out), 6);
    plus = 0;

    // Saturation: accumulator clamps, then drains upward.
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, 8'd127);
    idle(300);
    check("sat_drain", int'(spin_out), angle_m);

    // Reset mid-drain drops the residual at once.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'd100);
    idle(3);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_spin_out", int'(spin_out), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle(40);
    check("no_residual_after_reset", int'(spin_out), 0);

    // Randomised mix of ticks, single samples and sample bursts.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          plus = 1'($urandom); minus = 1'($urandom); fast = 1'($urandom);
          for (int k = 0; k < 5; k++) begin
            d = 8'($urandom_range(0, 40) - 20);
            cyc(k < 2, 1'($urandom), d);
          end
        end
        1: begin
          cyc(1'b0, 1'b1, 8'($urandom));
          idle($urandom_range(0, 3));
        end
        2: begin
          n = $urandom_range(2, 6);
          for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 60) - 30));
        end
        default: idle($urandom_range(1, 10));
      endcase
    end
    idle(400);
    check("queue_drained", exp_q.size(), 0);
    check("final_angle", int'(spin_out), angle_m);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
